// File: rtl/gen_handshake_req_ctrl.sv
// gen_handshake_req_ctrl: source side of a 4-phase req/ack
// handshake that hands one word at a time to a foreign clock domain.
module gen_handshake_req_ctrl #(
  parameter int unsigned     DP      = 2,
  parameter int unsigned     DW      = 32,
  parameter int unsigned     TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          done_o,
  output logic          err_o,
  input  logic          err_clr_i,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] cnt_inc;
  logic [DP-1:0]   sync_q, sync_d;
  logic            ack_s;
  logic            to_en;
  logic            to_hit;

  assign ack_s   = sync_q[DP-1];
  assign to_en   = (TIMEOUT != '0);
  assign to_hit  = to_en && (cnt_q == TO_LAST);
  assign ready_o = (state_q == S_IDLE) && !ack_s;
  assign req_o   = req_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

  // Saturating increment; frozen at zero when the timeout is disabled
  always_comb begin
    cnt_inc = cnt_q;
    if (to_en && (cnt_q != '1)) begin
      cnt_inc = cnt_q + 1'b1;
    end
  end

  // Shift ack_i through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[DP-2:0], ack_i};
  end

  // Handshake sequencing, timeout supervision and sticky error
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (valid_i && ready_o) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_REL;
          cnt_d   = '0;
        end else if (to_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REL: begin
        if (!ack_s) begin
          state_d = S_IDLE;
        end else if (to_hit) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Register state, outputs and synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
    end
  end

endmodule
